// File: rtl/alu_acc_pkg.sv
// Shared types and constants for the accumulator stage: opcodes, default width,
// and signed-limit helpers used when saturation is enabled.
package alu_acc_pkg;

    localparam int unsigned ACC_WIDTH = 4;
    localparam int unsigned MAX_WIDTH = 64;

    typedef enum logic [1:0] {
        OP_CLR  = 2'b00,
        OP_LOAD = 2'b01,
        OP_ADD  = 2'b10,
        OP_SUB  = 2'b11
    } op_t;

    // Largest positive two's complement value of a w-bit word (0111..1).
    function automatic logic [MAX_WIDTH-1:0] signed_max(input int unsigned w);
        return (MAX_WIDTH'(1) << (w - 1)) - MAX_WIDTH'(1);
    endfunction

    // Most negative two's complement value of a w-bit word (1000..0).
    function automatic logic [MAX_WIDTH-1:0] signed_min(input int unsigned w);
        return MAX_WIDTH'(1) << (w - 1);
    endfunction

endpackage

// File: rtl/alu_accumulator_if.sv
// Command/result bus of the accumulator stage: upstream valid/ready command
// channel plus the downstream result/flags channel.
interface alu_accumulator_if
    import alu_acc_pkg::*;
#(
    parameter int unsigned WIDTH = ACC_WIDTH
) ();

    logic             in_valid;
    logic             in_ready;
    op_t              op;
    logic [WIDTH-1:0] operand;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] acc;
    logic             carry;
    logic             zero;
    logic             ovf;

    modport master (
        output in_valid, op, operand, out_ready,
        input  in_ready, out_valid, acc, carry, zero, ovf
    );

    modport slave (
        input  in_valid, op, operand, out_ready,
        output in_ready, out_valid, acc, carry, zero, ovf
    );

endinterface

// File: rtl/acc_addsub_core.sv
// Combinational A +/- B: mode m=1 subtracts by inverting B and injecting a carry-in.
module acc_addsub_core #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             m,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             ovf
);

    logic [WIDTH-1:0] b_eff;

    assign b_eff = b ^ {WIDTH{m}};
    assign {carry, sum} = (WIDTH+1)'(a) + (WIDTH+1)'(b_eff) + (WIDTH+1)'(m);
    // Signed overflow: addends agree in sign but the result does not.
    assign ovf = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/alu_accumulator.sv
// Flow-controlled accumulator stage (CLR/LOAD/ADD/SUB) with carry/zero/ovf flags.
// Define ALU_ACCUMULATOR_SAT_EN to saturate ADD/SUB overflow to the signed limits.
module alu_accumulator
    import alu_acc_pkg::*;
#(
    parameter int unsigned WIDTH = ACC_WIDTH
) (
    input logic               clk,
    input logic               rst,
    alu_accumulator_if.slave  bus
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             carry_q, carry_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;

    logic             accept;
    logic [WIDTH-1:0] core_sum;
    logic             core_carry;
    logic             core_ovf;

`ifdef ALU_ACCUMULATOR_SAT_EN
    localparam logic [WIDTH-1:0] SAT_MAX = WIDTH'(signed_max(WIDTH));
    localparam logic [WIDTH-1:0] SAT_MIN = WIDTH'(signed_min(WIDTH));
`endif

    assign bus.in_ready  = (state_q == ST_EMPTY) || bus.out_ready;
    assign accept        = bus.in_valid && bus.in_ready;

    assign bus.out_valid = (state_q == ST_FULL);
    assign bus.acc       = acc_q;
    assign bus.carry     = carry_q;
    assign bus.zero      = zero_q;
    assign bus.ovf       = ovf_q;

    acc_addsub_core #(.WIDTH(WIDTH)) u_core (
        .a     (acc_q),
        .b     (bus.operand),
        .m     (bus.op == OP_SUB),
        .sum   (core_sum),
        .carry (core_carry),
        .ovf   (core_ovf)
    );

    // State and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            acc_q   <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
        end
    end

    // Next-state and next-result logic; everything holds unless a command is accepted
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        zero_d  = zero_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            ST_EMPTY: if (accept) state_d = ST_FULL;
            ST_FULL: begin
                if (accept)              state_d = ST_FULL;
                else if (bus.out_ready)  state_d = ST_EMPTY;
            end
            default: state_d = ST_EMPTY;
        endcase

        if (accept) begin
            unique case (bus.op)
                OP_CLR: begin
                    acc_d   = '0;
                    carry_d = 1'b0;
                    ovf_d   = 1'b0;
                end
                OP_LOAD: begin
                    acc_d   = bus.operand;
                    carry_d = 1'b0;
                    ovf_d   = 1'b0;
                end
                default: begin
                    carry_d = core_carry;
                    ovf_d   = core_ovf;
`ifdef ALU_ACCUMULATOR_SAT_EN
                    // Overflow direction follows the accumulator sign (addends share it).
                    if (core_ovf) acc_d = acc_q[WIDTH-1] ? SAT_MIN : SAT_MAX;
                    else          acc_d = core_sum;
`else
                    acc_d   = core_sum;
`endif
                end
            endcase
            zero_d = (acc_d == '0);
        end
    end

    a_op_known: assert property (@(posedge clk) disable iff (rst)
        bus.in_valid |-> !$isunknown(bus.op));

endmodule
